// File: rtl/gpio_unit_if.sv
// CPU data-bus port of the GPIO block: chip enable, read/byte-write strobes, word address, data.
// The master drives the request; the slave returns rdata combinationally.
interface gpio_unit_if #(
  parameter int ADDR_WIDTH = 4
);
  logic                  ce;
  logic                  re;
  logic [3:0]            we;
  logic [ADDR_WIDTH-1:0] addr;
  logic [31:0]           wdata;
  logic [31:0]           rdata;

  modport master (output ce, re, we, addr, wdata, input rdata);
  modport slave  (input ce, re, we, addr, wdata, output rdata);
endinterface

// File: rtl/gpio_unit.sv
// Memory-mapped GPIO: out/dir regs, 2-flop sync, prescaled debounce, edge capture, level irq.
// Writes land on the clock edge, reads are zero-latency combinational; never stalls the bus.
module gpio_unit #(
  parameter int WIDTH      = 32,
  parameter int DB_WIDTH   = 16,
  parameter int ADDR_WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  gpio_unit_if.slave       bus,
  input  logic [WIDTH-1:0] gpio_in,
  output logic [WIDTH-1:0] gpio_out,
  output logic [WIDTH-1:0] gpio_oe,
  output logic             irq
);

  logic [ADDR_WIDTH-1:0] addr;
  logic [31:0]           idx;
  logic [31:0]           lane;
  logic [31:0]           wd;
  logic                  wr;

  assign addr = bus.addr;
  assign idx  = 32'(addr);
  assign lane = {{8{bus.we[3]}}, {8{bus.we[2]}}, {8{bus.we[1]}}, {8{bus.we[0]}}};
  assign wd   = bus.wdata & lane;
  assign wr   = bus.ce & (|bus.we);

  logic wr_dout, wr_dir, wr_rise, wr_fall, wr_pend, wr_ien, wr_db, wr_set, wr_clr;
  assign wr_dout = wr && (idx == 32'd0);
  assign wr_dir  = wr && (idx == 32'd1);
  assign wr_rise = wr && (idx == 32'd3);
  assign wr_fall = wr && (idx == 32'd4);
  assign wr_pend = wr && (idx == 32'd5);
  assign wr_ien  = wr && (idx == 32'd6);
  assign wr_db   = wr && (idx == 32'd7);
  assign wr_set  = wr && (idx == 32'd8);
  assign wr_clr  = wr && (idx == 32'd9);

  logic [WIDTH-1:0] lane_w, wd_w;
  assign lane_w = lane[WIDTH-1:0];
  assign wd_w   = wd[WIDTH-1:0];

  logic [WIDTH-1:0]    data_out, dir, rise_en, fall_en, pend, irq_en;
  logic [WIDTH-1:0]    sync1, sync2, sample, stable;
  logic [DB_WIDTH-1:0] db_reload, db_reload_nx, cnt;

  assign db_reload_nx = (db_reload & ~lane[DB_WIDTH-1:0]) | wd[DB_WIDTH-1:0];

  logic             tick;
  logic [WIDTH-1:0] agree, stable_nx, rise, fall, pend_set;

  // A reload write at the terminal count restarts the period instead of ticking.
  always_comb begin
    tick      = (db_reload != '0) && (cnt == '0) && !wr_db;
    agree     = ~(sync2 ^ sample);
    stable_nx = stable;
    if (db_reload == '0)
      stable_nx = sync2;
    else if (tick)
      stable_nx = (stable & ~agree) | (sync2 & agree);
    rise     = ~stable & stable_nx;
    fall     = stable & ~stable_nx;
    pend_set = (rise & rise_en) | (fall & fall_en);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_out  <= '0;
      dir       <= '0;
      rise_en   <= '0;
      fall_en   <= '0;
      pend      <= '0;
      irq_en    <= '0;
      db_reload <= '0;
      cnt       <= '0;
      sync1     <= '0;
      sync2     <= '0;
      sample    <= '0;
      stable    <= '0;
    end else begin
      sync1  <= gpio_in;
      sync2  <= sync1;
      stable <= stable_nx;
      if (tick)
        sample <= sync2;

      if (wr_db) begin
        db_reload <= db_reload_nx;
        cnt       <= db_reload_nx;
      end else if (cnt == '0) begin
        cnt <= db_reload;
      end else begin
        cnt <= cnt - DB_WIDTH'(1);
      end

      if (wr_dout)
        data_out <= (data_out & ~lane_w) | wd_w;
      else if (wr_set)
        data_out <= data_out | wd_w;
      else if (wr_clr)
        data_out <= data_out & ~wd_w;

      if (wr_dir)  dir     <= (dir & ~lane_w) | wd_w;
      if (wr_rise) rise_en <= (rise_en & ~lane_w) | wd_w;
      if (wr_fall) fall_en <= (fall_en & ~lane_w) | wd_w;
      if (wr_ien)  irq_en  <= (irq_en & ~lane_w) | wd_w;

      // New edges beat a simultaneous W1C on the same bit.
      pend <= (pend & ~(wr_pend ? wd_w : '0)) | pend_set;
    end
  end

  logic [31:0] rd;
  always_comb begin
    rd = '0;
    if (bus.ce && bus.re) begin
      case (idx)
        32'd0:   rd[WIDTH-1:0]    = data_out;
        32'd1:   rd[WIDTH-1:0]    = dir;
        32'd2:   rd[WIDTH-1:0]    = stable;
        32'd3:   rd[WIDTH-1:0]    = rise_en;
        32'd4:   rd[WIDTH-1:0]    = fall_en;
        32'd5:   rd[WIDTH-1:0]    = pend;
        32'd6:   rd[WIDTH-1:0]    = irq_en;
        32'd7:   rd[DB_WIDTH-1:0] = db_reload;
        default: rd = '0;
      endcase
    end
  end

  assign bus.rdata = rd;
  assign gpio_out  = data_out;
  assign gpio_oe   = dir;
  assign irq       = |(pend & irq_en);

endmodule

// File: tb/tb_gpio_unit.sv
// Directed-vector bench for gpio_unit: reset, byte lanes, bypass latency, debounce, interrupts.
module tb_gpio_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] gpio_in;
  logic [31:0] gpio_out;
  logic [31:0] gpio_oe;
  logic        irq;

  int n_vec  = 0;
  int n_miss = 0;

  gpio_unit_if #(.ADDR_WIDTH(4)) bus ();

  gpio_unit #(.WIDTH(32), .DB_WIDTH(16), .ADDR_WIDTH(4)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus.slave),
    .gpio_in  (gpio_in),
    .gpio_out (gpio_out),
    .gpio_oe  (gpio_oe),
    .irq      (irq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  task automatic bus_wr(input int idx, input logic [31:0] data, input logic [3:0] be);
    @(negedge clk);
    bus.ce    = 1'b1;
    bus.re    = 1'b0;
    bus.we    = be;
    bus.addr  = 4'(idx);
    bus.wdata = data;
    @(negedge clk);
    bus.ce = 1'b0;
    bus.we = 4'b0000;
  endtask

  task automatic bus_rd(input int idx, output logic [31:0] data);
    bus.ce   = 1'b1;
    bus.re   = 1'b1;
    bus.we   = 4'b0000;
    bus.addr = 4'(idx);
    #1;
    data   = bus.rdata;
    bus.ce = 1'b0;
    bus.re = 1'b0;
  endtask

  logic [31:0] d;
  int          ones;

  initial begin
    rst_n     = 1'b0;
    gpio_in   = '0;
    bus.ce    = 1'b0;
    bus.re    = 1'b0;
    bus.we    = 4'b0000;
    bus.addr  = '0;
    bus.wdata = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Build up state, then reset mid-cycle and confirm it is all gone.
    bus_wr(0, 32'hFFFF_FFFF, 4'b1111);
    bus_wr(1, 32'h0000_FFFF, 4'b1111);
    bus_wr(3, 32'h0000_0020, 4'b1111);
    bus_wr(6, 32'h0000_0020, 4'b1111);
    @(negedge clk);
    gpio_in = 32'h0000_0020;
    repeat (5) @(negedge clk);
    chk("pre_rst_irq", 32'(irq), 32'd1);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("rst_gpio_out", gpio_out, 32'h0);
    chk("rst_gpio_oe", gpio_oe, 32'h0);
    chk("rst_irq", 32'(irq), 32'd0);
    gpio_in = '0;
    for (int i = 0; i < 10; i++) begin
      bus_rd(i, d);
      chk($sformatf("rst_idx%0d", i), d, 32'h0);
    end
    @(negedge clk);
    rst_n = 1'b1;

    // Byte lanes on direct, set and clear writes.
    bus_wr(0, 32'hAABB_CCDD, 4'b0101);
    bus_rd(0, d);
    chk("dout_lanes", d, 32'h00BB_00DD);
    chk("gpio_out_lanes", gpio_out, 32'h00BB_00DD);
    bus_wr(8, 32'h0000_FF00, 4'b1111);
    bus_rd(0, d);
    chk("out_set", d, 32'h00BB_FFDD);
    bus_wr(9, 32'h0000_00FF, 4'b1111);
    bus_rd(0, d);
    chk("out_clr", d, 32'h00BB_FF00);
    bus_wr(9, 32'hFFFF_FFFF, 4'b0100);
    chk("out_clr_lane", gpio_out, 32'h0000_FF00);
    bus_wr(1, 32'h1234_0F0F, 4'b0011);
    chk("dir_lanes", gpio_oe, 32'h0000_0F0F);
    bus.ce = 1'b1; bus.re = 1'b0; bus.addr = 4'd0;
    #1;
    chk("rd_no_re", bus.rdata, 32'h0);
    bus.ce = 1'b0;

    // Bypass: change presented before edge 1 shows up after edge 3.
    @(negedge clk);
    gpio_in = 32'h0000_0008;
    @(negedge clk); bus_rd(2, d); chk("byp_e1", d, 32'h0);
    @(negedge clk); bus_rd(2, d); chk("byp_e2", d, 32'h0);
    @(negedge clk); bus_rd(2, d); chk("byp_e3", d, 32'h0000_0008);
    gpio_in = '0;
    repeat (4) @(negedge clk);

    // Debounce with a 10-cycle tick.
    bus_wr(7, 32'hFFFF_0009, 4'b1111);
    bus_rd(7, d);
    chk("db_reload", d, 32'h0000_0009);
    gpio_in = 32'h0000_0001;
    repeat (5) @(negedge clk);
    gpio_in = '0;
    ones = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      bus_rd(2, d);
      if (d[0]) ones++;
    end
    chk("db_glitch", 32'(ones), 32'd0);
    @(negedge clk);
    gpio_in = 32'h0000_0001;
    repeat (8) @(negedge clk);
    bus_rd(2, d);
    chk("db_hold_early", d, 32'h0);
    repeat (17) @(negedge clk);
    bus_rd(2, d);
    chk("db_hold_late", d, 32'h0000_0001);

    // Interrupt on rise of pin 0, with bypass debounce.
    bus_wr(7, 32'h0, 4'b1111);
    gpio_in = '0;
    repeat (5) @(negedge clk);
    bus_rd(5, d);
    chk("pend_idle", d, 32'h0);
    bus_wr(3, 32'h1, 4'b1111);
    bus_wr(6, 32'h1, 4'b1111);
    gpio_in = 32'h0000_0001;
    repeat (5) @(negedge clk);
    bus_rd(5, d);
    chk("pend_rise", d, 32'h1);
    chk("irq_rise", 32'(irq), 32'd1);
    bus_wr(5, 32'h1, 4'b1110);
    bus_rd(5, d);
    chk("w1c_lane", d, 32'h1);

    // W1C and a new rise on the same edge: the set wins.
    gpio_in = '0;
    repeat (5) @(negedge clk);
    @(negedge clk);
    gpio_in = 32'h0000_0001;
    @(negedge clk);
    bus_wr(5, 32'h1, 4'b1111);
    bus_rd(5, d);
    chk("collide_pend", d, 32'h1);
    chk("collide_irq", 32'(irq), 32'd1);
    bus_wr(5, 32'h1, 4'b1111);
    chk("w1c_irq", 32'(irq), 32'd0);
    bus_rd(5, d);
    chk("w1c_pend", d, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/gpio_unit.md
Name: gpio_unit

Overview:
- Memory-mapped GPIO peripheral on the CPU data bus, downstream of the bus controller; selected by the controller's gpio_ce.
- Provides output data and direction registers, 2-flop input synchronisation, a shared-prescaler input debouncer, per-pin rise/fall edge capture, and a level interrupt line.
- Writes take effect on the clock edge. Reads are combinational so the single-cycle core sees data in the same cycle.

Parameters:
- WIDTH, 32, number of GPIO pins (1..32); unused upper register bits read 0 and ignore writes.
- DB_WIDTH, 16, width of the debounce prescaler reload register and counter.
- ADDR_WIDTH, 4, word-index bits of the register address.

Ports:
- clk  input  1  system clock, all state on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- ce  input  1  chip enable from the bus controller (gpio_ce).
- re  input  1  bus read enable.
- we  input  4  bus byte write enables; we[i] qualifies wdata[8i+7:8i].
- addr  input  ADDR_WIDTH  word index (bus_addr[ADDR_WIDTH+1:2]).
- wdata  input  32  bus write data.
- rdata  output  32  bus read data, combinational.
- gpio_in  input  WIDTH  asynchronous pad inputs.
- gpio_out  output  WIDTH  pad output values (= DATA_OUT).
- gpio_oe  output  WIDTH  pad output enables (= DIR, 1 = drive).
- irq  output  1  level interrupt to the core.

Behaviour:
- Register map (word index: name, access):
  - 0: DATA_OUT, RW
  - 1: DIR, RW
  - 2: DATA_IN, RO, debounced
  - 3: RISE_EN, RW
  - 4: FALL_EN, RW
  - 5: IRQ_PEND, W1C
  - 6: IRQ_EN, RW
  - 7: DB_RELOAD, RW, low DB_WIDTH bits
  - 8: OUT_SET, WO, writing 1 sets DATA_OUT bits
  - 9: OUT_CLR, WO, writing 1 clears DATA_OUT bits
- Reads of indices 8-15 return 0.
- Write strobe = ce & |we. Byte lanes are honoured on every register, including W1C/W1S/W1 clear.
- Writes to RO or unmapped indices are ignored.
- rdata = selected register when ce & re, else 32'h0. Reads have no side effects.
- Reset: all registers, synchroniser flops, stable inputs, prescaler and pending cleared to 0. Therefore gpio_out = 0, gpio_oe = 0, irq = 0, rdata = 0.
- Synchroniser: two flops per pin, giving sync[WIDTH-1:0].
- Debounce, DB_RELOAD == 0: stable <= sync every cycle. A pad change is visible in DATA_IN 3 cycles after it is presented before a clock edge.
- Debounce, DB_RELOAD != 0:
  - Prescaler counts down from DB_RELOAD to 0, then asserts a one-cycle tick and reloads.
  - On each tick, sample <= sync. stable bit k updates to sample[k] only when two consecutive tick samples agree.
  - A write to DB_RELOAD reloads the prescaler on the same edge.
- Edge detect on each stable update: rise = ~old & new, fall = old & ~new.
- pend[k] sets on (rise[k] & RISE_EN[k]) | (fall[k] & FALL_EN[k]).
- A W1C to IRQ_PEND clears the written bits. If a set and a W1C hit the same bit in the same cycle, the set wins.
- irq = |(IRQ_PEND & IRQ_EN), combinational from registers. It deasserts on the edge that clears the last enabled pending bit.
- DATA_OUT update priority within a cycle: reset > direct write to index 0 > OUT_SET/OUT_CLR (only one index is written per cycle).
- gpio_out is driven for all pins regardless of DIR. Pad muxing is external.
- Reset asserted mid-debounce or with pending bits aborts everything to the reset state. After release, stable re-converges from 0: any pin already high at release produces a rise edge and can set pend if enabled.

Test Plan:
- Reset check: assert rst_n=0 asynchronously mid-cycle -> gpio_out=0, gpio_oe=0, irq=0 immediately; read indices 0-9 -> all 0.
- Byte lanes: write 0xAABBCCDD to DATA_OUT with we=4'b0101 -> readback 0x00BB00DD and gpio_out matches. Then OUT_SET 0x0000FF00 -> 0x00BBFFDD. Then OUT_CLR 0x000000FF -> 0x00BBFF00.
- Bypass latency: DB_RELOAD=0, gpio_in[3] 0->1 -> DATA_IN bit 3 reads 1 exactly 3 cycles later.
- Debounce filtering: DB_RELOAD=9 (tick every 10 cycles):
  - 1-tick glitch on gpio_in[0] -> DATA_IN[0] never changes.
  - Level held for 25 cycles -> DATA_IN[0]=1 after the second agreeing tick.
- Interrupt: RISE_EN=1, IRQ_EN=1, pin 0 rises -> IRQ_PEND=0x1 and irq=1. Then W1C 0x1 -> irq=0 next edge.
- Collision: W1C of IRQ_PEND bit 0 in the same cycle as a new rise on pin 0 -> pend[0] stays 1 and irq stays 1.
